// File: rtl/mem_stage_load_unit.sv
// MEM pipeline stage: drives the data-memory handshake for loads, aligns and extends the
// returned data, and registers the result (or a fault) into the MEM/WB pipeline register.
module mem_stage_load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_MEM,
    input  logic        regwrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [31:0] ALU_data_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        regwrite_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] wb_data_WB,
    output logic        load_fault_WB
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_count;

    logic        w_legal;
    logic        w_aligned;
    logic        w_goodLoad;
    logic        w_badLoad;
    logic        w_timeout;
    logic        w_done;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;

    always_comb begin
        w_legal   = 1'b1;
        w_aligned = 1'b1;
        case (funct3_MEM)
            3'b000, 3'b100: w_aligned = 1'b1;
            3'b001, 3'b101: w_aligned = ~ALU_data_MEM[0];
            3'b010:         w_aligned = (ALU_data_MEM[1:0] == 2'b00);
            default:        w_legal   = 1'b0;
        endcase
    end

    assign w_goodLoad = memread_MEM & w_legal & w_aligned;
    assign w_badLoad  = memread_MEM & ~(w_legal & w_aligned);

    // A response arriving in the last allowed WAIT cycle beats the timeout; in REQ no data can count yet.
    assign w_timeout = ((r_state == ST_REQ) || ((r_state == ST_WAIT) && !dmem_rvalid))
                       && (r_count == TIMEOUT_LAST);
    assign w_done    = (r_state == ST_WAIT) && dmem_rvalid;

    always_comb begin
        case (r_state)
            ST_IDLE: stall_MEM = w_goodLoad;
            ST_REQ:  stall_MEM = ~w_timeout;
            ST_WAIT: stall_MEM = ~(dmem_rvalid | w_timeout);
            default: stall_MEM = 1'b0;
        endcase
    end

    assign dmem_req  = (r_state == ST_REQ);
    assign dmem_addr = {ALU_data_MEM[31:2], 2'b00};

    always_comb begin
        case (ALU_data_MEM[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = ALU_data_MEM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_MEM)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadData = {24'h0, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadData = {16'h0, w_half};
            default: w_loadData = dmem_rdata;
        endcase
    end

    // Handshake FSM and MEM/WB register; stalled edges load a bubble so a load writes back once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= 16'h0;
            regwrite_WB   <= 1'b0;
            rd_WB         <= 5'h0;
            wb_data_WB    <= 32'h0;
            load_fault_WB <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= 16'h0;
                    if (w_goodLoad) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_count <= r_count + 16'h1;
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (dmem_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count + 16'h1;
                    if (dmem_rvalid || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (stall_MEM) begin
                regwrite_WB   <= 1'b0;
                load_fault_WB <= 1'b0;
            end else if (w_timeout || w_badLoad) begin
                regwrite_WB   <= 1'b0;
                load_fault_WB <= 1'b1;
                rd_WB         <= rd_MEM;
                wb_data_WB    <= ALU_data_MEM;
            end else if (w_done) begin
                regwrite_WB   <= regwrite_MEM;
                load_fault_WB <= 1'b0;
                rd_WB         <= rd_MEM;
                wb_data_WB    <= w_loadData;
            end else begin
                regwrite_WB   <= regwrite_MEM;
                load_fault_WB <= 1'b0;
                rd_WB         <= rd_MEM;
                wb_data_WB    <= ALU_data_MEM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_load_unit.sv
// Directed bench for mem_stage_load_unit; a second instance with a short timeout
// exercises the load abort path.
module tb_mem_stage_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread_MEM;
    logic        regwrite_MEM;
    logic [2:0]  funct3_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] ALU_data_MEM;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        stallMain, reqMain, regwriteMain, faultMain;
    logic [31:0] addrMain, dataMain;
    logic [4:0]  rdMain;
    logic        stallShort, reqShort, regwriteShort, faultShort;
    logic [31:0] addrShort, dataShort;
    logic [4:0]  rdShort;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    mem_stage_load_unit dutMain (
        .clk(clk), .reset(reset),
        .memread_MEM(memread_MEM), .regwrite_MEM(regwrite_MEM), .funct3_MEM(funct3_MEM),
        .rd_MEM(rd_MEM), .ALU_data_MEM(ALU_data_MEM), .stall_MEM(stallMain),
        .dmem_req(reqMain), .dmem_addr(addrMain), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .regwrite_WB(regwriteMain), .rd_WB(rdMain), .wb_data_WB(dataMain),
        .load_fault_WB(faultMain)
    );

    mem_stage_load_unit #(.TIMEOUT_CYCLES(4)) dutShort (
        .clk(clk), .reset(reset),
        .memread_MEM(memread_MEM), .regwrite_MEM(regwrite_MEM), .funct3_MEM(funct3_MEM),
        .rd_MEM(rd_MEM), .ALU_data_MEM(ALU_data_MEM), .stall_MEM(stallShort),
        .dmem_req(reqShort), .dmem_addr(addrShort), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .regwrite_WB(regwriteShort), .rd_WB(rdShort), .wb_data_WB(dataShort),
        .load_fault_WB(faultShort)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic rw, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] alu);
        memread_MEM  = mr;
        regwrite_MEM = rw;
        funct3_MEM   = f3;
        rd_MEM       = rd;
        ALU_data_MEM = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Walks one load cycle by cycle, raising gnt/rvalid on the given cycle indices.
    task automatic runLoad(input bit useShort, input logic [31:0] rdata, input int gntCycle,
                           input int rvCycle, input int lastCycle, output int stalls,
                           output int reqs, output int writes, output logic [31:0] lastAddr,
                           output bit addrStable);
        stalls = 0;
        reqs = 0;
        writes = 0;
        lastAddr = 32'h0;
        addrStable = 1'b1;
        for (int c = 0; c <= lastCycle; c++) begin
            dmem_gnt    = (c == gntCycle);
            dmem_rvalid = (c == rvCycle);
            dmem_rdata  = rdata;
            #1;
            if (useShort ? stallShort : stallMain) stalls++;
            if (useShort ? reqShort : reqMain) begin
                if (reqs > 0 && lastAddr != (useShort ? addrShort : addrMain)) addrStable = 1'b0;
                lastAddr = useShort ? addrShort : addrMain;
                reqs++;
            end
            tick();
            if (c < lastCycle && (useShort ? regwriteShort : regwriteMain)) writes++;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic goodLoad(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] rdata, input int gntCycle,
                            input int rvCycle, input int expReqs, input logic [31:0] expData);
        int stalls, reqs, writes;
        logic [31:0] lastAddr;
        bit stable;
        applyStimulus(1'b1, 1'b1, f3, rd, addr);
        runLoad(1'b0, rdata, gntCycle, rvCycle, rvCycle, stalls, reqs, writes, lastAddr, stable);
        checkOutput({tag, " stalls"}, 32'(stalls), 32'(rvCycle));
        checkOutput({tag, " reqCycles"}, 32'(reqs), 32'(expReqs));
        checkOutput({tag, " dmem_addr"}, lastAddr, {addr[31:2], 2'b00});
        checkOutput({tag, " addrStable"}, 32'(stable), 32'd1);
        checkOutput({tag, " earlyWrites"}, 32'(writes), 32'd0);
        checkOutput({tag, " regwrite_WB"}, 32'(regwriteMain), 32'd1);
        checkOutput({tag, " rd_WB"}, 32'(rdMain), 32'(rd));
        checkOutput({tag, " wb_data_WB"}, dataMain, expData);
        checkOutput({tag, " fault"}, 32'(faultMain), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
        tick();
        checkOutput({tag, " singleWrite"}, 32'(regwriteMain), 32'd0);
    endtask

    task automatic badLoad(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr);
        applyStimulus(1'b1, 1'b1, f3, rd, addr);
        #1;
        checkOutput({tag, " stall"}, 32'(stallMain), 32'd0);
        checkOutput({tag, " req"}, 32'(reqMain), 32'd0);
        tick();
        checkOutput({tag, " regwrite_WB"}, 32'(regwriteMain), 32'd0);
        checkOutput({tag, " fault"}, 32'(faultMain), 32'd1);
        checkOutput({tag, " rd_WB"}, 32'(rdMain), 32'(rd));
        checkOutput({tag, " wb_data_WB"}, dataMain, addr);
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls, reqs, writes;
        logic [31:0] lastAddr;
        bit stable;

        reset = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
        #2;
        checkOutput("reset req", 32'(reqMain), 32'd0);
        checkOutput("reset regwrite", 32'(regwriteMain), 32'd0);
        checkOutput("reset rd", 32'(rdMain), 32'd0);
        checkOutput("reset data", dataMain, 32'h0);
        checkOutput("reset fault", 32'(faultMain), 32'd0);
        #20;
        reset = 1'b1;
        tick();

        applyStimulus(1'b0, 1'b1, 3'b000, 5'd5, 32'hDEADBEEF);
        #1;
        checkOutput("alu stall", 32'(stallMain), 32'd0);
        tick();
        checkOutput("alu regwrite_WB", 32'(regwriteMain), 32'd1);
        checkOutput("alu rd_WB", 32'(rdMain), 32'd5);
        checkOutput("alu wb_data_WB", dataMain, 32'hDEADBEEF);
        checkOutput("alu fault", 32'(faultMain), 32'd0);

        goodLoad("LB", 3'b000, 5'd7, 32'h1003, 32'h80FF7F01, 1, 2, 1, 32'hFFFFFF80);
        goodLoad("LBU", 3'b100, 5'd7, 32'h1003, 32'h80FF7F01, 1, 2, 1, 32'h00000080);
        goodLoad("LH", 3'b001, 5'd12, 32'h2002, 32'h80011234, 4, 6, 4, 32'hFFFF8001);
        goodLoad("LHU", 3'b101, 5'd13, 32'h2000, 32'h8001F234, 1, 2, 1, 32'h0000F234);
        goodLoad("LB1", 3'b000, 5'd14, 32'h1001, 32'h80FF7F01, 1, 2, 1, 32'h0000007F);
        goodLoad("LW", 3'b010, 5'd15, 32'h3004, 32'hCAFEF00D, 2, 4, 2, 32'hCAFEF00D);

        badLoad("LW misaligned", 3'b010, 5'd4, 32'h2001);
        badLoad("LHU misaligned", 3'b101, 5'd6, 32'h2003);
        badLoad("funct3 011", 3'b011, 5'd8, 32'h0000_0040);

        resetPulse();
        applyStimulus(1'b1, 1'b1, 3'b010, 5'd8, 32'h3000);
        runLoad(1'b1, 32'hAAAAAAAA, 1, -1, 4, stalls, reqs, writes, lastAddr, stable);
        checkOutput("timeout stalls", 32'(stalls), 32'd4);
        checkOutput("timeout earlyWrites", 32'(writes), 32'd0);
        checkOutput("timeout regwrite_WB", 32'(regwriteShort), 32'd0);
        checkOutput("timeout fault", 32'(faultShort), 32'd1);
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h55555555;
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("stray rvalid regwrite", 32'(regwriteShort), 32'd0);
        checkOutput("stray rvalid fault", 32'(faultShort), 32'd0);
        checkOutput("stray rvalid req", 32'(reqShort), 32'd0);

        resetPulse();
        applyStimulus(1'b0, 1'b1, 3'b000, 5'd3, 32'h12345678);
        tick();
        checkOutput("pre-reset data", dataMain, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 3'b010, 5'd9, 32'h4000);
        tick();
        checkOutput("pre-reset req", 32'(reqMain), 32'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        checkOutput("wait stall", 32'(stallMain), 32'd1);
        checkOutput("wait req", 32'(reqMain), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset req", 32'(reqMain), 32'd0);
        checkOutput("midreset regwrite", 32'(regwriteMain), 32'd0);
        checkOutput("midreset rd", 32'(rdMain), 32'd0);
        checkOutput("midreset data", dataMain, 32'h0);
        checkOutput("midreset fault", 32'(faultMain), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
        tick();
        reset = 1'b1;

        applyStimulus(1'b1, 1'b1, 3'b010, 5'd10, 32'h5000);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h11111111;
        #1;
        checkOutput("idle rvalid stall", 32'(stallMain), 32'd1);
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("idle rvalid req", 32'(reqMain), 32'd1);
        checkOutput("idle rvalid regwrite", 32'(regwriteMain), 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h5A5A5A5A;
        #1;
        checkOutput("post-reset done stall", 32'(stallMain), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 32'h0);
        checkOutput("post-reset regwrite", 32'(regwriteMain), 32'd1);
        checkOutput("post-reset rd", 32'(rdMain), 32'd10);
        checkOutput("post-reset data", dataMain, 32'h5A5A5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
